// File: rtl/sm_muldiv.sv
// Iterative multiply/divide unit (shift-add multiply, restoring divide) with HI/LO result registers.
// Signed operations run on magnitudes; the sign is applied in a final fix-up cycle.
`default_nettype none

module sm_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;      // sign of product / quotient
  logic               neg_r;      // sign of remainder
  logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;        // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_nxt;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH+1:0]   div_diff;

  assign mag_a = (op[0] && srcA[WIDTH-1]) ? -srcA : srcA;
  assign mag_b = (op[0] && srcB[WIDTH-1]) ? -srcB : srcB;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration of either algorithm; quotient bits shift into the vacated dividend bits.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    div_sh   = acc[2*WIDTH-1:WIDTH-1];
    div_diff = {1'b0, div_sh} - {2'b00, opnd};
    if (is_div) begin
      if (div_diff[WIDTH+1]) acc_nxt = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else                   acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            neg_q  <= op[0] & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
            neg_r  <= op[0] & srcA[WIDTH-1];
            cnt    <= '0;
            if (op[1]) begin
              opnd <= mag_b;
              acc  <= {{WIDTH{1'b0}}, mag_a};
            end else begin
              opnd <= mag_a;
              acc  <= {{WIDTH{1'b0}}, mag_b};
            end
          end
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          // Divide-by-zero and MIN/-1 fall out of the plain algorithm plus sign fix-up.
          if (is_div) begin
            lo <= neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            hi <= neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
          end else begin
            {hi, lo} <= neg_q ? -acc : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sm_muldiv.sv
// Randomised and directed bench for sm_muldiv against an arithmetic reference model.
`timescale 1ns/1ps

module tb_sm_muldiv;

  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srcA = '0, srcB = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  sm_muldiv #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Returns {hi, lo} as the architecture defines it.
  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (mop)
      2'd0: p = {32'd0, a} * {32'd0, b};
      2'd1: p = 64'(sa * sb);
      2'd2: if (b == 0) p = {a, 32'hFFFFFFFF};
            else        p = {a % b, a / b};
      default: begin
        if (b == 0) p = {a, (a[31] ? 32'd1 : 32'hFFFFFFFF)};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'd0, 32'h80000000};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {32'(r), 32'(q)};
        end
      end
    endcase
    return p;
  endfunction

  // Cycle-level expectations: an accepted start keeps busy for WIDTH+1 cycles, then one done cycle.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] pend = '0;
  int          cyc = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      cyc++;
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          {m_hi, m_lo} = pend;
        end
      end else if (start) begin
        pend = model(op, srcA, srcB);
        m_left = WIDTH + 1;
      end
    end
  end

  logic [1:0]  t_op [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd3};
  logic [31:0] t_a  [7] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'd100, 32'hFFFFFFF9, 32'h80000000, 32'd5, 32'hFFFFFFFB};
  logic [31:0] t_b  [7] = '{32'hFFFFFFFF, 32'd5, 32'd7, 32'd2, 32'hFFFFFFFF, 32'd0, 32'd0};
  logic [31:0] t_hi [7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'h0, 32'h5, 32'hFFFFFFFB};
  logic [31:0] t_lo [7] = '{32'h00000001, 32'hFFFFFFF1, 32'hE, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'h1};

  logic        lit_en = 1'b0;
  logic [31:0] lit_hi = '0, lit_lo = '0;
  logic        gap_en = 1'b0;
  int          last_done = 0;

  // Single compare process: model pins first, then every cycle.
  initial begin
    logic [63:0] mp;
    for (int i = 0; i < 7; i++) begin
      mp = model(t_op[i], t_a[i], t_b[i]);
      vectors++;
      if (mp !== {t_hi[i], t_lo[i]}) begin
        miscompares++;
        $display("FAIL model_pin%0d: got %h, required %h", i, mp, {t_hi[i], t_lo[i]});
      end
    end
    forever begin
      @(negedge clk);
      vectors++;
      if (busy !== (m_left > 0) || done !== m_done || hi !== m_hi || lo !== m_lo) begin
        miscompares++;
        $display("FAIL cycle%0d busy/done/hi/lo: actual %b/%b/%h/%h required %b/%b/%h/%h",
                 cyc, busy, done, hi, lo, (m_left > 0), m_done, m_hi, m_lo);
      end
      if (done === 1'b1 && lit_en) begin
        vectors++;
        if (hi !== lit_hi || lo !== lit_lo) begin
          miscompares++;
          $display("FAIL literal hi/lo: actual %h/%h required %h/%h", hi, lo, lit_hi, lit_lo);
        end
      end
      if (done === 1'b1) begin
        if (gap_en) begin
          vectors++;
          if (cyc - last_done != 34) begin
            miscompares++;
            $display("FAIL back_to_back gap: actual %0d required 34", cyc - last_done);
          end
        end
        last_done = cyc;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) begin
      $display("FAIL wait_idle timeout: busy=%b required 0", busy);
      $fatal(1, "timeout");
    end
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      $display("FAIL wait_done timeout: done=%b required 1", done);
      $fatal(1, "timeout");
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; srcA = a; srcB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_lit(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int ignore_at);
    wait_idle();
    lit_hi = eh; lit_lo = el; lit_en = 1'b1;
    issue(o, a, b);
    if (ignore_at >= 0) begin
      repeat (ignore_at) @(negedge clk);
      issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    end
    wait_done();
    @(negedge clk);
    lit_en = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_lit(t_op[i], t_a[i], t_b[i], t_hi[i], t_lo[i], -1);

    // Second start at cycle 10 of a MULTU must be ignored.
    run_lit(2'd0, 32'h12345678, 32'd9, 32'h0, 32'hA3D70A38, 9);

    // Back-to-back: restart in the done cycle.
    wait_idle();
    issue(2'd2, 32'd100, 32'd7);
    wait_done();
    op = 2'd3; srcA = 32'hFFFFFFF9; srcB = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    gap_en = 1'b1;
    lit_hi = 32'hFFFFFFFF; lit_lo = 32'hFFFFFFFD; lit_en = 1'b1;
    wait_done();
    @(negedge clk);
    gap_en = 1'b0; lit_en = 1'b0;

    // Asynchronous abort in the middle of RUN.
    wait_idle();
    issue(2'd1, 32'hFFFFFFFD, 32'd5);
    repeat (11) @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_lit(2'd2, 32'd100, 32'd7, 32'h2, 32'hE, -1);

    // Random traffic; starts while busy are ignored by both model and DUT.
    for (int c = 0; c < 2500; c++) begin
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom_range(0, 3));
      srcA  = pick();
      srcB  = pick();
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
